// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: parity_mode bit positions, FSM state encodings, parity helper
package uart_pkg;

  // parity_mode bit positions, also used by the receiver
  localparam int PM_EN_BIT  = 1;
  localparam int PM_ODD_BIT = 0;

  // frame state encodings, also used by the receiver
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // even parity of the byte, inverted for odd mode
  function automatic logic parity_of(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter; tick marks the last clock of each bit
module uart_baud_tick #(
  parameter int CLK_DIV_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  input  logic                     restart,
  output logic                     tick
);

  localparam logic [CLK_DIV_WIDTH-1:0] ONE = CLK_DIV_WIDTH'(1);

  // Divisor in force for the current bit; reloaded only at bit boundaries so
  // a clk_div change mid-bit takes effect from the next bit onward.
  logic [CLK_DIV_WIDTH-1:0] r_div;
  logic [CLK_DIV_WIDTH-1:0] r_cnt;
  logic [CLK_DIV_WIDTH-1:0] w_last;

  // last count value of a bit; divisors 0 and 1 both mean a one-clock bit
  always_comb begin
    w_last = '0;
    if (r_div > ONE) begin
      w_last = r_div - ONE;
    end
  end

  assign tick = (r_cnt == w_last);

  // count clocks within a bit, reloading the divisor at each boundary or restart
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_cnt <= '0;
      r_div <= '0;
    end else if (restart || tick) begin
      r_cnt <= '0;
      r_div <= clk_div;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with one-byte holding register and optional parity
module uart_tx
  import uart_pkg::*;
#(
  parameter int   CLK_DIV_WIDTH = 8,
  parameter logic START_BIT     = 1'b0,
  parameter logic STOP_BIT      = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  input  logic [1:0]               parity_mode,
  input  logic                     we,
  input  logic [7:0]               datai,
  output logic                     full,
  output logic                     overflow,
  output logic                     tx,
  output logic                     busy
);

  uart_state_e r_state;
  uart_state_e w_state_nxt;
  logic [7:0]  r_hold;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic [2:0]  r_bitcnt;
  logic [2:0]  w_bitcnt_nxt;
  logic        r_par_en;
  logic        w_par_en_nxt;
  logic        r_par_bit;
  logic        w_par_bit_nxt;
  logic        w_tx_nxt;
  logic        w_load;
  logic        w_tick;
  logic        w_accept;
  logic        w_full_nxt;
  logic        w_ovf_nxt;
  logic        w_busy_nxt;

  uart_baud_tick #(
    .CLK_DIV_WIDTH(CLK_DIV_WIDTH)
  ) u_baud (
    .clk     (clk),
    .resetb  (resetb),
    .clk_div (clk_div),
    .restart (w_load),
    .tick    (w_tick)
  );

  // Next-state and next-line-level logic. tx is registered, so each branch
  // computes the level the line takes for the bit that starts on this edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bitcnt_nxt  = r_bitcnt;
    w_par_en_nxt  = r_par_en;
    w_par_bit_nxt = r_par_bit;
    w_tx_nxt      = tx;
    w_load        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = STOP_BIT;
        if (full) begin
          w_load = 1'b1;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt  = ST_DATA;
          w_bitcnt_nxt = 3'd0;
          w_tx_nxt     = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bitcnt == 3'd7) begin
            if (r_par_en) begin
              w_state_nxt = ST_PARITY;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = ST_STOP;
              w_tx_nxt    = STOP_BIT;
            end
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            w_shift_nxt  = r_shift >> 1;
            w_tx_nxt     = r_shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = STOP_BIT;
        end
      end
      ST_STOP: begin
        w_tx_nxt = STOP_BIT;
        if (w_tick) begin
          if (full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = STOP_BIT;
      end
    endcase

    // Frame start: shifter, parity setup and start bit all on the same edge,
    // which lets a pending byte follow the stop bit with no idle gap.
    if (w_load) begin
      w_state_nxt   = ST_START;
      w_shift_nxt   = r_hold;
      w_bitcnt_nxt  = 3'd0;
      w_par_en_nxt  = parity_mode[PM_EN_BIT];
      w_par_bit_nxt = parity_of(r_hold, parity_mode[PM_ODD_BIT]);
      w_tx_nxt      = START_BIT;
    end
  end

  // Holding-register handshake. A write on the edge that empties the holding
  // register is accepted, so full stays set for the new byte.
  always_comb begin
    w_accept   = we && (!full || w_load);
    w_ovf_nxt  = we && full && !w_load;
    w_full_nxt = full;
    if (w_accept) begin
      w_full_nxt = 1'b1;
    end else if (w_load) begin
      w_full_nxt = 1'b0;
    end
    w_busy_nxt = (w_state_nxt != ST_IDLE) || w_full_nxt;
  end

  // frame state, shifter and line register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      tx        <= STOP_BIT;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_par_en  <= w_par_en_nxt;
      r_par_bit <= w_par_bit_nxt;
      tx        <= w_tx_nxt;
    end
  end

  // holding register and status flags
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_hold   <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold <= datai;
      end
      full     <= w_full_nxt;
      overflow <= w_ovf_nxt;
      busy     <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level line model
module tb_uart_tx;

  localparam int W = 8;

  logic         clk         = 1'b0;
  logic         resetb      = 1'b0;
  logic         we          = 1'b0;
  logic [W-1:0] clk_div     = W'(8);
  logic [1:0]   parity_mode = 2'b00;
  logic [7:0]   datai       = 8'h00;
  logic         full;
  logic         overflow;
  logic         tx;
  logic         busy;

  logic [W-1:0] div_q = '0;
  logic         par;
  int           n_vec = 0;
  int           n_err = 0;

  uart_tx #(
    .CLK_DIV_WIDTH(W)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .clk_div     (clk_div),
    .parity_mode (parity_mode),
    .we          (we),
    .datai       (datai),
    .full        (full),
    .overflow    (overflow),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // divisor presented at each rising edge: the one a bit starting there uses
  always @(posedge clk) div_q <= clk_div;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    datai = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic idle_for(input int n);
    for (int k = 0; k < n; k++) begin
      chk("idle tx", 32'(tx), 32'd1);
      chk("idle busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
  endtask

  // Expected line: start, 8 data LSB first, optional parity, stop; each bit
  // lasts max(divisor,1) clocks using the divisor seen at that bit's start.
  task automatic check_frame(input logic [7:0] d, input logic [1:0] pm,
                             input bit wait_fall, output logic par_seen);
    logic q[$];
    logic ones_odd;
    int   n;
    int   dur;
    par_seen = 1'b0;
    ones_odd = (($countones(d) % 2) == 1);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pm[1]) q.push_back(ones_odd ^ pm[0]);
    q.push_back(1'b1);
    if (wait_fall) begin
      n = 0;
      while (tx !== 1'b0 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("full at frame start", 32'(full), 32'd0);
    for (int i = 0; i < q.size(); i++) begin
      dur = (div_q <= W'(1)) ? 1 : int'(div_q);
      for (int c = 0; c < dur; c++) begin
        chk($sformatf("tx bit%0d clk%0d", i, c), 32'(tx), 32'(q[i]));
        chk($sformatf("busy bit%0d", i), 32'(busy), 32'd1);
        if (pm[1] && i == 9 && c == 0) par_seen = tx;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [1:0] pm;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);

    // 0xA5, clk_div=8, no parity; write on the first clock after release
    resetb = 1'b1;
    wr(8'hA5);
    chk("lat tx", 32'(tx), 32'd1);
    chk("lat full", 32'(full), 32'd1);
    chk("lat busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_frame(8'hA5, 2'b00, 1'b0, par);
    chk("A5 busy after", 32'(busy), 32'd0);
    idle_for(3);

    // parity even then odd on 0x07
    clk_div = W'(2);
    parity_mode = 2'b10;
    wr(8'h07);
    check_frame(8'h07, 2'b10, 1'b1, par);
    chk("parity even", 32'(par), 32'd1);
    idle_for(2);
    parity_mode = 2'b11;
    wr(8'h07);
    check_frame(8'h07, 2'b11, 1'b1, par);
    chk("parity odd", 32'(par), 32'd0);
    idle_for(2);

    // back-to-back: 0x22 written during 0x11 follows with no gap
    parity_mode = 2'b00;
    clk_div = W'(3);
    wr(8'h11);
    @(negedge clk);
    fork
      check_frame(8'h11, 2'b00, 1'b0, par);
      begin
        repeat (4) @(negedge clk);
        wr(8'h22);
        chk("b2b pending full", 32'(full), 32'd1);
      end
    join
    check_frame(8'h22, 2'b00, 1'b0, par);
    chk("b2b busy after", 32'(busy), 32'd0);
    idle_for(2);

    // third write while full: overflow pulse, byte dropped
    wr(8'h11);
    @(negedge clk);
    fork
      check_frame(8'h11, 2'b00, 1'b0, par);
      begin
        repeat (2) @(negedge clk);
        wr(8'h22);
        chk("ovf pending full", 32'(full), 32'd1);
        chk("ovf none yet", 32'(overflow), 32'd0);
        wr(8'h33);
        chk("ovf pulse", 32'(overflow), 32'd1);
        @(negedge clk);
        chk("ovf one clock", 32'(overflow), 32'd0);
      end
    join
    check_frame(8'h22, 2'b00, 1'b0, par);
    idle_for(12);

    // reset during data bit 4 with a byte pending
    clk_div = W'(4);
    wr(8'h2C);
    @(negedge clk);
    wr(8'h55);
    repeat (19) @(negedge clk);
    chk("pre-reset bit4", 32'(tx), 32'd0);
    chk("pre-reset full", 32'(full), 32'd1);
    resetb = 1'b0;
    #1;
    chk("async rst tx", 32'(tx), 32'd1);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst full", 32'(full), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
    wr(8'h96);
    chk("post-rst full", 32'(full), 32'd1);
    @(negedge clk);
    check_frame(8'h96, 2'b00, 1'b0, par);
    idle_for(12);

    // clk_div=0: one clock per bit, ten-clock frame
    clk_div = W'(0);
    wr(8'hFF);
    @(negedge clk);
    check_frame(8'hFF, 2'b00, 1'b0, par);
    chk("div0 busy after", 32'(busy), 32'd0);
    idle_for(2);

    // randomized frames with occasional mid-frame divisor/parity_mode changes
    for (int it = 0; it < 12; it++) begin
      d = 8'($urandom);
      pm = 2'($urandom);
      clk_div = W'($urandom_range(0, 6));
      parity_mode = pm;
      wr(d);
      fork
        check_frame(d, pm, 1'b1, par);
        begin
          if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            clk_div = W'($urandom_range(0, 6));
            parity_mode = 2'($urandom);
          end
        end
      join
      idle_for(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV_WIDTH, default 8, giving the width of the bit-period divisor.
REQ-002 SHALL have parameter START_BIT, default 0, giving the line level of the start bit.
REQ-003 SHALL have parameter STOP_BIT, default 1, giving the line level of the stop bit and of the idle line.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port resetb, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port clk_div, input, CLK_DIV_WIDTH bits: clocks per bit.
REQ-007 SHALL have port parity_mode, input, 2 bits: [1]=parity bit enabled, [0]=odd parity.
REQ-008 SHALL have port we, input, 1 bit: write strobe for datai.
REQ-009 SHALL have port datai, input, 8 bits: byte to transmit.
REQ-010 SHALL have port full, output reg, 1 bit: holding register occupied; writes are not accepted while high.
REQ-011 SHALL have port overflow, output reg, 1 bit: one-cycle pulse when we arrives while full.
REQ-012 SHALL have port tx, output reg, 1 bit: serial line.
REQ-013 SHALL have port busy, output reg, 1 bit: high while a frame is on the line or full is high.

Function
REQ-014 SHALL transmit each frame in this order: start bit, datai[0] through datai[7] (LSB first), parity bit if parity_mode[1]=1, then one stop bit; frame length is 10 bits, or 11 bits with parity.
REQ-015 SHALL compute the parity bit as the XOR of the 8 data bits, inverted when parity_mode[0]=1.
REQ-016 SHALL sample parity_mode when a frame starts and hold that value until the frame ends.
REQ-017 SHALL hold each bit on tx for exactly clk_div clocks.
REQ-018 SHALL treat clk_div values of 0 and 1 both as a one-clock bit.
REQ-019 SHALL restart the bit-period counter at 0 at every frame start.
REQ-020 SHALL apply a change of clk_div in the middle of a frame from the next bit boundary onward.
REQ-021 SHALL accept a write when we=1 and full=0; datai is captured into the holding register and full goes to 1 on the next clock.
REQ-022 SHALL, when idle with full=1, load the holding register into the shifter, clear full, and drive tx to START_BIT, all on the same clock edge; tx therefore falls 2 clocks after an accepted we.
REQ-023 SHALL allow a write into the holding register while a frame is being sent.
REQ-024 SHALL start a pending byte so that its start bit follows the final stop-bit clock of the previous frame with no idle gap.
REQ-025 SHALL, when we=1 and full=1, ignore datai, leave the holding register unchanged, and pulse overflow for one clock.
REQ-026 SHALL accept we on the same clock that full clears: that write is captured and full stays 1.
REQ-027 SHALL use a state machine with states IDLE, START, DATA, PARITY and STOP, with a 3-bit data-bit counter.
REQ-028 SHALL make these state transitions:
  - IDLE->START when full=1;
  - START->DATA at the bit boundary;
  - DATA->PARITY or DATA->STOP after bit 7, depending on the sampled parity_mode[1];
  - PARITY->STOP at the bit boundary;
  - STOP->START if full=1, otherwise STOP->IDLE.
REQ-029 SHALL drive tx to STOP_BIT in IDLE and STOP.
REQ-030 SHALL drop busy to 0 on the clock after the last stop-bit clock when no byte is pending.

Reset
REQ-031 SHALL, while resetb=0, force the following values:
  - tx=STOP_BIT;
  - full=0, overflow=0, busy=0;
  - state=IDLE;
  - counters=0;
  - holding register=0.
REQ-032 SHALL abort any frame in progress when reset is asserted, driving tx to STOP_BIT immediately and discarding any pending byte.
REQ-033 SHALL accept a write on the first clock after resetb deasserts.

Structure
REQ-034 SHALL take the parity_mode bit positions and the state encodings from the shared UART constants include file, which the receiver also uses.
REQ-035 SHALL implement the bit-period counter as one sub-module, uart_baud_tick, with inputs clk, resetb, clk_div and restart, and output tick.
REQ-036 SHALL use uart_baud_tick as its only sub-module.

Verification
REQ-037 SHALL cover: clk_div=8, parity off, write 0xA5 -> tx low 8 clocks, then 1,0,1,0,0,1,0,1 at 8 clocks each, then high 8 clocks; busy high for 80 clocks.
REQ-038 SHALL cover: parity_mode=2'b10 and then 2'b11, write 0x07 -> parity bit 1 (even mode) and 0 (odd mode); 11-bit frame.
REQ-039 SHALL cover: write 0x11, then write 0x22 during the first frame -> second start bit immediately after the first stop bit with no gap; full clears at the second frame start.
REQ-040 SHALL cover: three writes while the first frame is active -> the third write pulses overflow once, only 0x11 and 0x22 are sent, and busy stays high through both frames.
REQ-041 SHALL cover: resetb asserted during data bit 4 -> tx=1, busy=0 and full=0 at once; a new write after release sends a clean frame.
REQ-042 SHALL cover: clk_div=0, write 0xFF -> each bit lasts one clock, with a 10-clock frame.
